// File: rtl/mem_pkg.sv
// Shared memory definitions used by the arbiter, the memory instance and all clients.
package mem_pkg;

   localparam int unsigned MEM_ADDR_W  = 12;
   localparam int unsigned MEM_DATA_W  = 16;
   localparam int unsigned MEM_NUM_REQ = 4;

   typedef struct packed {
      logic                  we;
      logic [MEM_ADDR_W-1:0] addr;
      logic [MEM_DATA_W-1:0] wdata;
   } access_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-port bundle of the arbiter; slave is the arbiter side.
interface mem_arbiter_if
   import mem_pkg::*;
#(
   parameter int unsigned NUM_REQ    = MEM_NUM_REQ,
   parameter int unsigned ADDR_WIDTH = MEM_ADDR_W,
   parameter int unsigned DATA_WIDTH = MEM_DATA_W
);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_we;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ-1:0]            rsp_valid;
   logic [DATA_WIDTH-1:0]         rsp_rdata;
   logic                          mem_we;
   logic [ADDR_WIDTH-1:0]         mem_addr;
   logic [DATA_WIDTH-1:0]         mem_din;
   logic [DATA_WIDTH-1:0]         mem_dout;
   logic                          busy;

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, mem_dout,
      output req_ready, rsp_valid, rsp_rdata, mem_we, mem_addr, mem_din, busy
   );

   modport master (
      output req_valid, req_we, req_addr, req_wdata, mem_dout,
      input  req_ready, rsp_valid, rsp_rdata, mem_we, mem_addr, mem_din, busy
   );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant; search starts at ptr and wraps upward.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic               advance_i,
   output logic [NUM_REQ-1:0] grant_o
);

   localparam int unsigned PTR_W = $clog2(NUM_REQ);

   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [PTR_W-1:0] gidx;
   logic [PTR_W-1:0] sel;
   logic             found;
   int unsigned      idx;

   always_comb begin
      grant_o = '0;
      gidx    = '0;
      found   = 1'b0;
      idx     = 0;
      sel     = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = 32'(ptr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         sel = PTR_W'(idx);
         if (!found && req_i[sel]) begin
            found        = 1'b1;
            grant_o[sel] = 1'b1;
            gidx         = sel;
         end
      end
   end

   // Next search starts just past the winner.
   always_comb begin
      ptr_d = ptr_q;
      if (advance_i) ptr_d = (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory among NUM_REQ requesters with a
// registered issue stage and fixed two-cycle read return.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = MEM_ADDR_W,
   parameter int unsigned DATA_WIDTH = MEM_DATA_W,
   parameter int unsigned NUM_REQ    = MEM_NUM_REQ
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);

   logic [NUM_REQ-1:0]    grant;
   logic                  accept;
   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;

   logic                  mem_we_q,   mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_din_q,  mem_din_d;
   logic [NUM_REQ-1:0]    rd1_q,      rd1_d;
   logic [NUM_REQ-1:0]    rd2_q,      rd2_d;
   logic                  busy_q,     busy_d;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .clk       (clk),
      .rst       (rst),
      .req_i     (bus.req_valid),
      .advance_i (accept),
      .grant_o   (grant)
   );

   assign accept = |grant;

   // One-hot mux of the granted requester's access.
   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_we    = bus.req_we[i];
            sel_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Idle cycles keep address/data so the memory sees a harmless read.
   always_comb begin
      mem_we_d   = accept & sel_we;
      mem_addr_d = accept ? sel_addr  : mem_addr_q;
      mem_din_d  = accept ? sel_wdata : mem_din_q;
      rd1_d      = (accept && !sel_we) ? grant : '0;
      rd2_d      = rd1_q;
      busy_d     = accept | (|rd1_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
         rd1_q      <= '0;
         rd2_q      <= '0;
         busy_q     <= 1'b0;
      end else begin
         mem_we_q   <= mem_we_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
         rd1_q      <= rd1_d;
         rd2_q      <= rd2_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.req_ready = grant;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_din   = mem_din_q;
   assign bus.rsp_valid = rd2_q;
   assign bus.rsp_rdata = bus.mem_dout;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: memory model, transaction-level reference model with a
// per-cycle compare, and directed scenarios with literal expectations.
module tb_mem_arbiter;
   import mem_pkg::*;

   localparam int unsigned N  = 4;
   localparam int unsigned AW = 12;
   localparam int unsigned DW = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   access_t        acc [N];
   logic [N-1:0]   rv;

   assign bus.req_valid = rv;
   always_comb begin
      for (int i = 0; i < N; i++) begin
         bus.req_we[i]               = acc[i].we;
         bus.req_addr[i*AW +: AW]    = acc[i].addr;
         bus.req_wdata[i*DW +: DW]   = acc[i].wdata;
      end
   end

   // Single-port memory: write or read per cycle, read output held otherwise.
   logic [DW-1:0] mem [4096];
   logic [DW-1:0] dout;
   always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
      else            dout <= mem[bus.mem_addr];
   end
   assign bus.mem_dout = dout;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;
   int last_wait;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: transaction order, shadow memory and response schedule.
   typedef struct {
      int            id;
      logic [DW-1:0] data;
      int            due;
   } rsp_t;

   rsp_t          q[$];
   int            m_ptr  = 0;
   logic          m_we   = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_din  = '0;
   bit            m_acc  = 1'b0;
   bit            pend_v = 1'b0;
   logic [AW-1:0] pend_a;
   logic [DW-1:0] pend_d;
   logic [DW-1:0] shadow [4096];
   int            edge_n = 0;

   function automatic int pick(input int ptr, input logic [N-1:0] v);
      for (int k = 0; k < N; k++) begin
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   always @(posedge clk or posedge rst) begin : model
      int g;
      edge_n++;
      if (rst) begin
         m_ptr  = 0;
         m_we   = 1'b0;
         m_addr = '0;
         m_din  = '0;
         m_acc  = 1'b0;
         pend_v = 1'b0;
         q.delete();
      end else begin
         if (pend_v) shadow[pend_a] = pend_d;
         pend_v = 1'b0;
         g      = pick(m_ptr, rv);
         m_acc  = (g >= 0);
         if (g >= 0) begin
            m_we   = acc[g].we;
            m_addr = acc[g].addr;
            m_din  = acc[g].wdata;
            m_ptr  = (g + 1) % N;
            if (acc[g].we) begin
               pend_v = 1'b1;
               pend_a = acc[g].addr;
               pend_d = acc[g].wdata;
            end else begin
               q.push_back('{g, shadow[acc[g].addr], edge_n + 1});
            end
         end else begin
            m_we = 1'b0;
         end
         while (q.size() > 0 && q[0].due < edge_n) void'(q.pop_front());
      end
   end

   always @(negedge clk) begin : compare
      int            g;
      logic [N-1:0]  er;
      bit            found;
      bit            eb;
      int            eid;
      logic [DW-1:0] ed;
      if (chk_en) begin
         g  = pick(m_ptr, rv);
         er = (g >= 0) ? N'(1 << g) : '0;
         found = 1'b0;
         eb    = m_acc;
         eid   = 0;
         ed    = '0;
         foreach (q[j]) begin
            if (q[j].due == edge_n) begin
               found = 1'b1;
               eid   = q[j].id;
               ed    = q[j].data;
            end
            if (q[j].due >= edge_n) eb = 1'b1;
         end
         chk("req_ready", 32'(bus.req_ready), 32'(er));
         chk("mem_we",    32'(bus.mem_we),    32'(m_we));
         chk("mem_addr",  32'(bus.mem_addr),  32'(m_addr));
         chk("mem_din",   32'(bus.mem_din),   32'(m_din));
         chk("busy",      32'(bus.busy),      32'(eb));
         chk("rsp_valid", 32'(bus.rsp_valid), found ? 32'(1 << eid) : 32'h0);
         if (found) chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(ed));
      end
   end

   // Raise a request, wait (bounded) for its grant, drop valid after the accept edge.
   task automatic issue(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int waited;
      waited = 0;
      acc[i] = '{we, a, d};
      rv[i]  = 1'b1;
      @(negedge clk);
      while (!bus.req_ready[i] && waited < 16) begin
         waited++;
         @(negedge clk);
      end
      if (waited >= 16) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout: requester %0d not granted after %0d cycles", i, waited);
      end
      last_wait = waited;
      @(posedge clk);
      #1;
      rv[i] = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_g [5];
      rv = '0;
      for (int i = 0; i < N; i++) acc[i] = '{1'b1, AW'(i), DW'(16'h1000 + i)};

      // Reset with every requester valid.
      rst = 1'b1;
      rv  = '1;
      repeat (2) @(posedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_ready",     32'(bus.req_ready), 32'h1);
      chk("rst_mem_we",    32'(bus.mem_we),    32'h0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      exp_g = '{0, 1, 2, 3, 0};
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("rr_order", 32'(bus.req_ready), 32'(1 << exp_g[k]));
      end
      @(posedge clk);
      #1 rv = '0;
      repeat (2) @(posedge clk);
      #1;

      // Requester 2: write then read back.
      issue(2, 1'b1, 12'h0A5, 16'hBEEF);
      issue(2, 1'b0, 12'h0A5, 16'h0000);
      @(negedge clk);
      chk("rd_not_early", 32'(bus.rsp_valid), 32'h0);
      @(negedge clk);
      chk("rd_valid", 32'(bus.rsp_valid), 32'h4);
      chk("rd_data",  32'(bus.rsp_rdata), 32'hBEEF);
      repeat (2) @(posedge clk);
      #1;

      // Back-to-back write (req 1) then read (req 3) of the same address.
      issue(1, 1'b1, 12'h123, 16'h5A5A);
      acc[3] = '{1'b0, 12'h123, 16'h0000};
      rv[3]  = 1'b1;
      @(negedge clk);
      chk("raw_no_bubble", 32'(bus.req_ready), 32'h8);
      @(posedge clk);
      #1 rv[3] = 1'b0;
      @(negedge clk);
      chk("raw_not_early", 32'(bus.rsp_valid), 32'h0);
      @(negedge clk);
      chk("raw_valid", 32'(bus.rsp_valid), 32'h8);
      chk("raw_data",  32'(bus.rsp_rdata), 32'h5A5A);
      repeat (2) @(posedge clk);
      #1;

      // Fairness: req 0 always valid, req 1 toggles.
      acc[0] = '{1'b0, 12'h0A5, 16'h0000};
      rv[0]  = 1'b1;
      for (int r = 0; r < 4; r++) begin
         issue(1, 1'b0, 12'h123, 16'h0000);
         chk("fair_wait", 32'(last_wait <= 1), 32'h1);
         @(negedge clk);
         chk("fair_req0", 32'(bus.req_ready), 32'h1);
         @(posedge clk);
         #1;
      end
      rv[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Stalled request holds its fields while the other wins (ptr = 1).
      issue(0, 1'b0, 12'h0A5, 16'h0000);
      acc[0] = '{1'b1, 12'h300, 16'h1111};
      acc[2] = '{1'b1, 12'h200, 16'h2222};
      rv     = 4'b0101;
      @(negedge clk);
      chk("stall_first", 32'(bus.req_ready), 32'h4);
      @(posedge clk);
      #1 rv[2] = 1'b0;
      @(negedge clk);
      chk("stall_second",   32'(bus.req_ready), 32'h1);
      chk("stall_addr_req2", 32'(bus.mem_addr), 32'h200);
      @(posedge clk);
      #1 rv[0] = 1'b0;
      @(negedge clk);
      chk("stall_we_req0",   32'(bus.mem_we),   32'h1);
      chk("stall_addr_req0", 32'(bus.mem_addr), 32'h300);
      chk("stall_din_req0",  32'(bus.mem_din),  32'h1111);
      repeat (2) @(posedge clk);
      #1;

      // Reset pulsed while a read is in flight.
      issue(3, 1'b0, 12'h0A5, 16'h0000);
      #2 rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("rst_drop", 32'(bus.rsp_valid), 32'h0);
         if (k == 1) #1 rst = 1'b0;
      end
      @(posedge clk);
      #1;
      issue(3, 1'b0, 12'h0A5, 16'h0000);
      @(negedge clk);
      @(negedge clk);
      chk("post_rst_valid", 32'(bus.rsp_valid), 32'h8);
      chk("post_rst_data",  32'(bus.rsp_rdata), 32'hBEEF);
      repeat (3) @(posedge clk);
      #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
